bsg_ring_node: RTL and testbench
================================

Name: bsg_ring_node

Overview:
- Per-tile ring station that plugs into one (x,y) slot of bsg_mesh_to_ring_stitch.
- Forward ring carries data packets; back ring (opposite direction) carries acknowledgements.
- Local client gets a valid/ready inject port and a valid/yumi eject port, limited to a bounded number of unacknowledged packets.
- Hop latency is one register per node; ring traffic always has priority over local injection.

Parameters:
- id_width_p, 6, width of node id (clog2 of node count).
- data_width_p, 32, payload width.
- eject_els_p, 2, eject FIFO depth.
- ack_els_p, 2, pending-ack FIFO depth.
- max_outstanding_p, 4, unacknowledged packets allowed per node.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- id_i  in  id_width_p  node id, static after reset, from stitch id_o.
- fwd_data_in_i  in  fwd_w  {v, dest, src, payload}, where fwd_w = 1+2*id_width_p+data_width_p.
- fwd_data_out_o  out  fwd_w  registered forward output.
- back_data_in_i  in  back_w  {v, dest}, where back_w = 1+id_width_p.
- back_data_out_o  out  back_w  registered back output.
- v_i  in  1  local inject valid.
- dest_i  in  id_width_p  inject destination.
- data_i  in  data_width_p  inject payload.
- ready_o  out  1  inject accepted this cycle when v_i & ready_o.
- v_o  out  1  eject valid.
- src_o  out  id_width_p  eject source id.
- data_o  out  data_width_p  eject payload.
- yumi_i  in  1  eject dequeue; legal only when v_o.
- outstanding_o  out  clog2(max_outstanding_p+1)  unacknowledged count.

Behaviour:
Reset (synchronous, active-high):
- Both ring output valids 0; both FIFOs empty; outstanding_o 0.
- All nodes must reset together; in-flight packets and acks are discarded.

Forward path, combinational per cycle, on incoming packet p:
- Eject when p.v & p.dest==id_i & eject FIFO not full & ack FIFO not full.
  - Enqueue {p.src, p.payload} into the eject FIFO.
  - Enqueue p.src into the ack FIFO.
  - Slot becomes free.
- Otherwise, if p.v: forward p unchanged. Deflection: a packet for this node that cannot be ejected laps the ring again.
- Inject on a free slot: ready_o = slot_free & outstanding_o < max_outstanding_p.
  - Need not wait for v_i; combinationally depends on fwd_data_in_i.
  - On v_i & ready_o, drive {1, dest_i, id_i, data_i}; otherwise drive v=0.
- The chosen word is registered into fwd_data_out_o (1-cycle hop).

Back path, on incoming ack a:
- If a.v & a.dest==id_i: consume it, decrement outstanding, slot becomes free.
- Otherwise forward a unchanged.
- Free slot with ack FIFO non-empty: send {1, head}, dequeue. Otherwise send v=0.
- Registered into back_data_out_o.

Outstanding counter:
- +1 on inject, -1 on ack consume, unchanged when both occur in the same cycle.
- Never exceeds max_outstanding_p or goes below 0; both are assertion-checked.

Self-addressed packets (dest_i==id_i) traverse the full ring and eject on return; the ack is consumed locally one lap later.

Eject FIFO:
- Not bypassing: v_o rises the cycle after enqueue.
- Simultaneous enqueue and dequeue when full is not allowed; the full check uses the current occupancy.

Decomposition:
- bsg_ring_node_pkg holds:
  - macros declaring the fwd and back packet structs from id_width_p/data_width_p;
  - fwd_w/back_w width functions, used by the stitch-level instantiation.
- Sub-module: reuse bsg_fifo_1r1w_small for both the eject and ack FIFOs.

Test Plan (4-node ring, ids 0..3, forward 0->1->2->3->0, back reverse, data_width_p=8):
- Reset held 5 cycles:
  - all fwd/back out v=0, outstanding_o=0, v_o=0, ready_o=1 on every node;
  - no ring activity after release with v_i=0.
- Single packet: node0 injects 0xA5 to node2 at cycle t.
  - node2 v_o=1, data_o=0xA5, src_o=0 at t+3.
  - node0 outstanding_o 1 from t+1, returns to 0 by t+8.
- Credit limit: max_outstanding_p=2, node2 ack FIFO blocked by holding its back slots busy.
  - node0 third inject sees ready_o=0 until the first ack is consumed, then accepts next cycle.
- Deflection: node2 eject FIFO full (eject_els_p=2, yumi_i=0), third packet 0x33 arrives.
  - It laps and reappears at node2 input 4 cycles later.
  - Pulse yumi_i once; 0x33 ejects on the next arrival, in order after the queued 2.
- Priority: node3 streams to node2 continuously while node1 asserts v_i.
  - node1 ready_o=0 each cycle its fwd_data_in_i is valid-not-for-node1; injects in the first bubble.
- Self-send: node3 injects 0x7E to 3.
  - Ejects at node3 at t+5 (4 hops + FIFO); outstanding returns to 0.
  - Mid-flight reset_i clears every FIFO, counter and valid the next cycle.

Source files
------------

// File: rtl/bsg_ring_node_pkg.sv
// Shared types and width helpers for bsg_ring_node and the stitch that
// instantiates it. Packet structs depend on module parameters, so they are
// declared through macros expanded inside each parameterised module.

`ifndef BSG_RING_NODE_PKG_MACROS
`define BSG_RING_NODE_PKG_MACROS

// Forward-ring packet: {v, dest, src, payload}, v in the MSB.
`define BSG_RING_NODE_DECLARE_FWD_PKT_S(id_w, data_w, name) \
    typedef struct packed {                                  \
        logic              v;                                \
        logic [id_w-1:0]   dest;                             \
        logic [id_w-1:0]   src;                              \
        logic [data_w-1:0] payload;                          \
    } name

// Back-ring acknowledgement: {v, dest}, v in the MSB.
`define BSG_RING_NODE_DECLARE_BACK_PKT_S(id_w, name) \
    typedef struct packed {                           \
        logic            v;                           \
        logic [id_w-1:0] dest;                        \
    } name

`endif

package bsg_ring_node_pkg;

    // Flattened width of one forward-ring word.
    function automatic int fwd_w(input int id_w, input int data_w);
        return 1 + 2 * id_w + data_w;
    endfunction

    // Flattened width of one back-ring word.
    function automatic int back_w(input int id_w);
        return 1 + id_w;
    endfunction

    // Width of a counter that must hold 0..max_val inclusive.
    function automatic int ctr_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Pointer width that stays at least one bit for single-entry storage.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO, register based, non-bypassing: data written
// in a cycle is visible on v_o/data_o from the following cycle. Full is
// decided on current occupancy, so a dequeue does not open room for an
// enqueue in the same cycle.

module bsg_fifo_1r1w_small
    import bsg_ring_node_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,

    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = ctr_w(els_p);
    localparam logic [cnt_w_lp-1:0] els_lp  = cnt_w_lp'(els_p);
    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                enq, deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_lp) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count_q != els_lp);
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i;

    // Next pointer and occupancy values from this cycle's enqueue/dequeue.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on enqueue only.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage has no reset; occupancy gates v_o, so stale
        // contents are never observed and the array can map to plain flops/RAM.
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // A dequeue is only legal while data is held.
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("bsg_fifo_1r1w_small: yumi_i asserted while empty");

endmodule

// File: rtl/bsg_ring_node.sv
// Ring station for one tile. The forward ring carries data packets and the
// back ring, running the opposite way, carries acknowledgements. Ring traffic
// always wins over local injection; each hop is one register.

module bsg_ring_node
    import bsg_ring_node_pkg::*;
#(
    parameter int id_width_p        = 6,
    parameter int data_width_p      = 32,
    parameter int eject_els_p       = 2,
    parameter int ack_els_p         = 2,
    parameter int max_outstanding_p = 4
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic [id_width_p-1:0]                        id_i,

    input  logic [fwd_w(id_width_p, data_width_p)-1:0]   fwd_data_in_i,
    output logic [fwd_w(id_width_p, data_width_p)-1:0]   fwd_data_out_o,
    input  logic [back_w(id_width_p)-1:0]                back_data_in_i,
    output logic [back_w(id_width_p)-1:0]                back_data_out_o,

    input  logic                                         v_i,
    input  logic [id_width_p-1:0]                        dest_i,
    input  logic [data_width_p-1:0]                      data_i,
    output logic                                         ready_o,

    output logic                                         v_o,
    output logic [id_width_p-1:0]                        src_o,
    output logic [data_width_p-1:0]                      data_o,
    input  logic                                         yumi_i,

    output logic [ctr_w(max_outstanding_p)-1:0]          outstanding_o
);

    `BSG_RING_NODE_DECLARE_FWD_PKT_S(id_width_p, data_width_p, fwd_pkt_s);
    `BSG_RING_NODE_DECLARE_BACK_PKT_S(id_width_p, back_pkt_s);

    localparam int cnt_w_lp  = ctr_w(max_outstanding_p);
    localparam int eject_w_lp = id_width_p + data_width_p;
    localparam logic [cnt_w_lp-1:0] max_out_lp = cnt_w_lp'(max_outstanding_p);

    fwd_pkt_s  fwd_in;
    fwd_pkt_s  fwd_d, fwd_q;
    back_pkt_s back_in;
    back_pkt_s back_d, back_q;

    logic [cnt_w_lp-1:0] outstanding_d, outstanding_q;

    // Eject and ack FIFO handshakes.
    logic                  eject_ready;
    logic                  ack_ready;
    logic                  ack_v;
    logic [id_width_p-1:0] ack_head;
    logic [eject_w_lp-1:0] eject_head;

    // Per-cycle decisions.
    logic eject;
    logic fwd_slot_free;
    logic inject;
    logic ack_consume;
    logic back_slot_free;
    logic ack_send;

    assign fwd_in  = fwd_data_in_i;
    assign back_in = back_data_in_i;

    // ---------------------------------------------------------------------
    // Forward ring
    // ---------------------------------------------------------------------

    // A packet for this node leaves the ring only if both its payload and
    // its acknowledgement have room; otherwise it deflects round the ring.
    assign eject = fwd_in.v & (fwd_in.dest == id_i) & eject_ready & ack_ready;

    assign fwd_slot_free = ~fwd_in.v | eject;

    // Ready does not wait for v_i; it reflects the slot and credit state.
    assign ready_o = fwd_slot_free & (outstanding_q < max_out_lp);
    assign inject  = v_i & ready_o;

    // Choose the word leaving on the forward ring this cycle.
    always_comb begin
        fwd_d = '0;
        if (inject) begin
            fwd_d = '{v: 1'b1, dest: dest_i, src: id_i, payload: data_i};
        end else if (fwd_in.v && !eject) begin
            fwd_d = fwd_in;
        end
    end

    // Forward hop register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_q <= '0;
        end else begin
            fwd_q <= fwd_d;
        end
    end

    assign fwd_data_out_o = fwd_q;

    // ---------------------------------------------------------------------
    // Back ring
    // ---------------------------------------------------------------------

    assign ack_consume    = back_in.v & (back_in.dest == id_i);
    assign back_slot_free = ~back_in.v | ack_consume;
    assign ack_send       = back_slot_free & ack_v;

    // Choose the word leaving on the back ring this cycle.
    always_comb begin
        back_d = '0;
        if (ack_send) begin
            back_d = '{v: 1'b1, dest: ack_head};
        end else if (back_in.v && !ack_consume) begin
            back_d = back_in;
        end
    end

    // Back hop register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            back_q <= '0;
        end else begin
            back_q <= back_d;
        end
    end

    assign back_data_out_o = back_q;

    // ---------------------------------------------------------------------
    // Outstanding-packet credit counter
    // ---------------------------------------------------------------------

    // Inject adds a credit in use, a consumed ack returns one; both together
    // leave the count unchanged.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({inject, ack_consume})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding_o = outstanding_q;

    // ---------------------------------------------------------------------
    // Local FIFOs
    // ---------------------------------------------------------------------

    bsg_fifo_1r1w_small #(
        .width_p (eject_w_lp),
        .els_p   (eject_els_p)
    ) eject_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (eject),
        .ready_o (eject_ready),
        .data_i  ({fwd_in.src, fwd_in.payload}),
        .v_o     (v_o),
        .data_o  (eject_head),
        .yumi_i  (yumi_i)
    );

    assign src_o  = eject_head[eject_w_lp-1:data_width_p];
    assign data_o = eject_head[data_width_p-1:0];

    bsg_fifo_1r1w_small #(
        .width_p (id_width_p),
        .els_p   (ack_els_p)
    ) ack_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (eject),
        .ready_o (ack_ready),
        .data_i  (fwd_in.src),
        .v_o     (ack_v),
        .data_o  (ack_head),
        .yumi_i  (ack_send)
    );

    // ---------------------------------------------------------------------
    // Credit sanity
    // ---------------------------------------------------------------------

    assert property (@(posedge clk_i) disable iff (reset_i)
                     outstanding_q <= max_out_lp)
        else $error("bsg_ring_node: outstanding count above limit");

    assert property (@(posedge clk_i) disable iff (reset_i)
                     ack_consume |-> (outstanding_q != '0))
        else $error("bsg_ring_node: ack received with nothing outstanding");

endmodule

// File: tb/tb_bsg_ring_node.sv
// Four-node ring (ids 0..3), forward 0->1->2->3->0, back ring reversed.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_bsg_ring_node;
    import bsg_ring_node_pkg::*;

    localparam int N      = 4;
    localparam int ID_W   = 2;
    localparam int DATA_W = 8;
    localparam int EJ_ELS = 2;
    localparam int AK_ELS = 2;
    localparam int MAXO   = 2;
    localparam int FW     = fwd_w(ID_W, DATA_W);
    localparam int BW     = back_w(ID_W);
    localparam int CW     = ctr_w(MAXO);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [FW-1:0]     fwd_out  [N];
    logic [BW-1:0]     back_out [N];
    logic              v_in     [N];
    logic [ID_W-1:0]   dest_in  [N];
    logic [DATA_W-1:0] data_in  [N];
    logic              ready    [N];
    logic              v_out    [N];
    logic [ID_W-1:0]   src_out  [N];
    logic [DATA_W-1:0] data_out [N];
    logic              yumi     [N];
    logic [CW-1:0]     outst    [N];

    int n_compared   = 0;
    int n_mismatched = 0;

    for (genvar g = 0; g < N; g++) begin : g_node
        bsg_ring_node #(
            .id_width_p        (ID_W),
            .data_width_p      (DATA_W),
            .eject_els_p       (EJ_ELS),
            .ack_els_p         (AK_ELS),
            .max_outstanding_p (MAXO)
        ) dut (
            .clk_i           (clk),
            .reset_i         (reset),
            .id_i            (ID_W'(g)),
            .fwd_data_in_i   (fwd_out[(g + N - 1) % N]),
            .fwd_data_out_o  (fwd_out[g]),
            .back_data_in_i  (back_out[(g + 1) % N]),
            .back_data_out_o (back_out[g]),
            .v_i             (v_in[g]),
            .dest_i          (dest_in[g]),
            .data_i          (data_in[g]),
            .ready_o         (ready[g]),
            .v_o             (v_out[g]),
            .src_o           (src_out[g]),
            .data_o          (data_out[g]),
            .yumi_i          (yumi[g]),
            .outstanding_o   (outst[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [FW-1:0] fpkt(input logic [ID_W-1:0] d, input logic [ID_W-1:0] s,
                                           input logic [DATA_W-1:0] p);
        return {1'b1, d, s, p};
    endfunction

    function automatic logic [BW-1:0] bpkt(input logic [ID_W-1:0] d);
        return {1'b1, d};
    endfunction

    // Every ring register, FIFO and counter empty.
    task automatic check_idle(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s fwd_out[%0d]", tag, i), 32'(fwd_out[i]), 32'h0);
            check($sformatf("%s back_out[%0d]", tag, i), 32'(back_out[i]), 32'h0);
            check($sformatf("%s v_o[%0d]", tag, i), 32'(v_out[i]), 32'h0);
            check($sformatf("%s outstanding[%0d]", tag, i), 32'(outst[i]), 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            v_in[i]    = 1'b0;
            dest_in[i] = '0;
            data_in[i] = '0;
            yumi[i]    = 1'b0;
        end

        // ---- reset held 5 cycles ----
        @(negedge clk);
        tick(4);
        check_idle("reset");
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset ready[%0d]", i), 32'(ready[i]), 32'h1);
        end
        reset = 1'b0;
        tick(4);
        check_idle("post-reset quiet");

        // ---- single packet node0 -> node2, 0xA5 ----
        v_in[0] = 1'b1; dest_in[0] = 2'd2; data_in[0] = 8'hA5;
        check("single ready", 32'(ready[0]), 32'h1);
        tick();                                   // accepted at E0
        v_in[0] = 1'b0;
        check("single outst t+1", 32'(outst[0]), 32'h1);
        check("single hop0", 32'(fwd_out[0]), 32'(fpkt(2'd2, 2'd0, 8'hA5)));
        check("single v_o early", 32'(v_out[2]), 32'h0);
        tick();                                   // E0+1
        check("single hop1", 32'(fwd_out[1]), 32'(fpkt(2'd2, 2'd0, 8'hA5)));
        tick();                                   // E0+2
        check("single v_o", 32'(v_out[2]), 32'h1);
        check("single data", 32'(data_out[2]), 32'hA5);
        check("single src", 32'(src_out[2]), 32'h0);
        check("single slot freed", 32'(fwd_out[2]), 32'h0);
        yumi[2] = 1'b1;
        tick();                                   // E0+3
        yumi[2] = 1'b0;
        check("single ack sent", 32'(back_out[2]), 32'(bpkt(2'd0)));
        check("single v_o popped", 32'(v_out[2]), 32'h0);
        tick();                                   // E0+4
        check("single outst pre-ack", 32'(outst[0]), 32'h1);
        check("single ack hop", 32'(back_out[1]), 32'(bpkt(2'd0)));
        tick();                                   // E0+5
        check("single outst done", 32'(outst[0]), 32'h0);
        check("single ack consumed", 32'(back_out[0]), 32'h0);
        tick(3);

        // ---- credit limit, then deflection at node2 ----
        v_in[0] = 1'b1; dest_in[0] = 2'd2; data_in[0] = 8'h11;
        check("credit ready 1st", 32'(ready[0]), 32'h1);
        tick();                                   // E0: 0x11 accepted
        data_in[0] = 8'h22;
        check("credit ready 2nd", 32'(ready[0]), 32'h1);
        tick();                                   // E0+1: 0x22 accepted
        data_in[0] = 8'h33;
        check("credit outst max", 32'(outst[0]), 32'h2);
        check("credit blocked", 32'(ready[0]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();                               // E0+2..E0+4
            check($sformatf("credit blocked +%0d", k + 2), 32'(ready[0]), 32'h0);
        end
        tick();                                   // E0+5: first ack consumed
        check("credit outst after ack", 32'(outst[0]), 32'h1);
        check("credit ready again", 32'(ready[0]), 32'h1);
        tick();                                   // E1: 0x33 accepted, 2nd ack consumed
        v_in[0] = 1'b0;
        check("credit inject+ack same cycle", 32'(outst[0]), 32'h1);
        check("deflect fifo head", 32'(data_out[2]), 32'h11);
        tick();                                   // E1+1
        check("deflect arrive 1", 32'(fwd_out[1]), 32'(fpkt(2'd2, 2'd0, 8'h33)));
        tick();                                   // E1+2
        check("deflect forwarded", 32'(fwd_out[2]), 32'(fpkt(2'd2, 2'd0, 8'h33)));
        check("deflect head kept", 32'(data_out[2]), 32'h11);
        yumi[2] = 1'b1;
        tick();                                   // E1+3
        yumi[2] = 1'b0;
        check("deflect head after pop", 32'(data_out[2]), 32'h22);
        tick();                                   // E1+4
        check("deflect lap node0", 32'(fwd_out[0]), 32'(fpkt(2'd2, 2'd0, 8'h33)));
        check("deflect node0 busy", 32'(ready[0]), 32'h1);
        tick();                                   // E1+5
        check("deflect arrive 2", 32'(fwd_out[1]), 32'(fpkt(2'd2, 2'd0, 8'h33)));
        tick();                                   // E1+6: ejected
        check("deflect ejected", 32'(fwd_out[2]), 32'h0);
        check("deflect order 22", 32'(data_out[2]), 32'h22);
        yumi[2] = 1'b1;
        tick();
        yumi[2] = 1'b0;
        check("deflect order 33", 32'(data_out[2]), 32'h33);
        check("deflect src", 32'(src_out[2]), 32'h0);
        yumi[2] = 1'b1;
        tick();
        yumi[2] = 1'b0;
        check("deflect drained", 32'(v_out[2]), 32'h0);
        tick(6);
        check("deflect outst done", 32'(outst[0]), 32'h0);

        // ---- priority: node3 streams to node2, node1 waits ----
        v_in[3] = 1'b1; dest_in[3] = 2'd2; data_in[3] = 8'h31;
        tick();                                   // E
        data_in[3] = 8'h32;
        tick();                                   // E+1
        v_in[3] = 1'b0;
        v_in[1] = 1'b1; dest_in[1] = 2'd3; data_in[1] = 8'h5C;
        check("prio ready 0 a", 32'(ready[1]), 32'h0);
        tick();                                   // E+2
        check("prio ready 0 b", 32'(ready[1]), 32'h0);
        check("prio pass-through", 32'(fwd_out[1]), 32'(fpkt(2'd2, 2'd3, 8'h31)));
        tick();                                   // E+3
        check("prio bubble ready", 32'(ready[1]), 32'h1);
        tick();                                   // E+4: node1 injects
        v_in[1] = 1'b0;
        check("prio injected", 32'(fwd_out[1]), 32'(fpkt(2'd3, 2'd1, 8'h5C)));
        check("prio outst node1", 32'(outst[1]), 32'h1);
        check("prio node2 head", 32'(data_out[2]), 32'h31);
        yumi[2] = 1'b1;
        tick();                                   // E+5
        check("prio node2 next", 32'(data_out[2]), 32'h32);
        tick();                                   // E+6
        yumi[2] = 1'b0;
        check("prio node2 drained", 32'(v_out[2]), 32'h0);
        check("prio node3 v_o", 32'(v_out[3]), 32'h1);
        check("prio node3 data", 32'(data_out[3]), 32'h5C);
        check("prio node3 src", 32'(src_out[3]), 32'h1);
        yumi[3] = 1'b1;
        tick();
        yumi[3] = 1'b0;
        tick(8);
        check("prio outst node3", 32'(outst[3]), 32'h0);
        check("prio outst node1 done", 32'(outst[1]), 32'h0);

        // ---- self-send node3 -> node3 ----
        v_in[3] = 1'b1; dest_in[3] = 2'd3; data_in[3] = 8'h7E;
        tick();                                   // E
        v_in[3] = 1'b0;
        tick(3);                                  // E+3
        check("self not yet", 32'(v_out[3]), 32'h0);
        check("self at node2 out", 32'(fwd_out[2]), 32'(fpkt(2'd3, 2'd3, 8'h7E)));
        tick();                                   // E+4
        check("self v_o", 32'(v_out[3]), 32'h1);
        check("self data", 32'(data_out[3]), 32'h7E);
        check("self src", 32'(src_out[3]), 32'h3);
        check("self outst", 32'(outst[3]), 32'h1);
        tick(4);                                  // E+8
        check("self outst lap", 32'(outst[3]), 32'h1);
        tick();                                   // E+9
        check("self outst done", 32'(outst[3]), 32'h0);

        // ---- mid-flight reset (0x7E still queued at node3) ----
        v_in[3] = 1'b1; dest_in[3] = 2'd3; data_in[3] = 8'h7F;
        tick();
        v_in[3] = 1'b0;
        tick();
        check("flight in ring", 32'(fwd_out[0]), 32'(fpkt(2'd3, 2'd3, 8'h7F)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid-flight reset");
        tick(6);
        check_idle("after reset quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
